// File: rtl/regfile_write_arbiter_pkg.sv
// Shared widths and writeback request types for the vector CPU register-file write path.
package vector_cpu_pkg;

  localparam int DATA_WIDTH    = 18;
  localparam int VECTOR_SIZE   = 8;
  localparam int WIDTH         = 8;
  localparam int ADDRESS_WIDTH = 4;
  localparam int REQUESTERS    = 2;
  localparam int REGISTERS     = 1 << ADDRESS_WIDTH;

  typedef logic [VECTOR_SIZE-1:0][WIDTH-1:0] vector_t;

  // One writeback request as presented by a requester (ALU or memory load).
  typedef struct packed {
    logic                     is_vector;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0]    scalar_data;
    vector_t                  vector_data;
  } wb_req_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus: requester handshake on one side, register-file write port on the other.
interface regfile_write_arbiter_if;
  import vector_cpu_pkg::*;

  logic [REQUESTERS-1:0]                    reqValid;
  logic [REQUESTERS-1:0]                    reqReady;
  logic [REQUESTERS-1:0]                    reqIsVector;
  logic [REQUESTERS-1:0][ADDRESS_WIDTH-1:0] reqAddress;
  logic [REQUESTERS-1:0][DATA_WIDTH-1:0]    reqScalarData;
  vector_t [REQUESTERS-1:0]                 reqVectorData;

  logic                                     writeEnableScalar;
  logic                                     writeEnableVector;
  logic [ADDRESS_WIDTH-1:0]                 writeAddress;
  logic [DATA_WIDTH-1:0]                    writeScalarData;
  vector_t                                  writeVectorData;

  // Environment side: requesters drive requests, Decode consumes the write port.
  modport master (
    output reqValid, reqIsVector, reqAddress, reqScalarData, reqVectorData,
    input  reqReady,
    input  writeEnableScalar, writeEnableVector, writeAddress, writeScalarData, writeVectorData
  );

  // Arbiter side.
  modport slave (
    input  reqValid, reqIsVector, reqAddress, reqScalarData, reqVectorData,
    output reqReady,
    output writeEnableScalar, writeEnableVector, writeAddress, writeScalarData, writeVectorData
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority moves past the last accepted requester.
module rr_arbiter #(
  parameter int REQUESTERS = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REQUESTERS-1:0] request,
  input  logic                  accept,
  output logic [REQUESTERS-1:0] grant
);

  localparam logic [REQUESTERS-1:0] ONE = REQUESTERS'(1);

  // mask_reg has ones at every requester index that currently outranks the wrap-around.
  logic [REQUESTERS-1:0] mask_reg;
  logic [REQUESTERS-1:0] mask_next;
  logic [REQUESTERS-1:0] masked;
  logic [REQUESTERS-1:0] pick_masked;
  logic [REQUESTERS-1:0] pick_any;

  // Lowest set bit among the high-priority requesters, else lowest set bit overall.
  assign masked      = request & mask_reg;
  assign pick_masked = masked & (~masked + ONE);
  assign pick_any    = request & (~request + ONE);
  assign grant       = (|masked) ? pick_masked : pick_any;

  // Keep only indices strictly above the winner; a winner at the top index wraps to all-zero,
  // which hands priority back to requester 0 through the unmasked path.
  assign mask_next = ~((grant << 1) - ONE);

  // Priority pointer moves only on a completed handshake.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mask_reg <= '1;
    end else if (accept) begin
      mask_reg <= mask_next;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Writeback arbiter for the Decode register files plus the busy-register scoreboard.
module regfile_write_arbiter
  import vector_cpu_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  regfile_write_arbiter_if.slave   bus,
  input  logic                     reserveValid,
  input  logic                     reserveIsVector,
  input  logic [ADDRESS_WIDTH-1:0] reserveAddress,
  input  logic                     queryIsVector,
  input  logic [ADDRESS_WIDTH-1:0] reg1Address,
  input  logic [ADDRESS_WIDTH-1:0] reg2Address,
  input  logic [ADDRESS_WIDTH-1:0] regDestinationAddress,
  output logic                     hazard
);

  logic [REQUESTERS-1:0] grant;
  logic                  accept;
  wb_req_t               req_entry [REQUESTERS];
  wb_req_t               req_gated [REQUESTERS];
  wb_req_t               selected;

  logic [REGISTERS-1:0]  busy_scalar_reg;
  logic [REGISTERS-1:0]  busy_scalar_next;
  logic [REGISTERS-1:0]  busy_vector_reg;
  logic [REGISTERS-1:0]  busy_vector_next;
  logic [REGISTERS-1:0]  query_busy;

  rr_arbiter #(
    .REQUESTERS (REQUESTERS)
  ) u_rr_arbiter (
    .clock   (clock),
    .reset   (reset),
    .request (bus.reqValid),
    .accept  (accept),
    .grant   (grant)
  );

  // The output register drains every cycle, so the grant alone is the ready.
  assign bus.reqReady = grant;
  assign accept       = |grant;

  // Pack each requester's fields and zero all but the granted one, so an OR selects it.
  for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_req
    assign req_entry[gi] = '{
      is_vector:   bus.reqIsVector[gi],
      address:     bus.reqAddress[gi],
      scalar_data: bus.reqScalarData[gi],
      vector_data: bus.reqVectorData[gi]
    };
    assign req_gated[gi] = grant[gi] ? req_entry[gi] : '0;
  end

  // OR-reduce the gated requests into the single accepted request.
  always_comb begin
    selected = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      selected = wb_req_t'(selected | req_gated[i]);
    end
  end

  // Capture the accepted request; enables are a one-cycle strobe, address/data hold when idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.writeEnableScalar <= 1'b0;
      bus.writeEnableVector <= 1'b0;
      bus.writeAddress      <= '0;
      bus.writeScalarData   <= '0;
      bus.writeVectorData   <= '0;
    end else begin
      bus.writeEnableScalar <= accept & ~selected.is_vector;
      bus.writeEnableVector <= accept &  selected.is_vector;
      if (accept) begin
        bus.writeAddress    <= selected.address;
        bus.writeScalarData <= selected.scalar_data;
        bus.writeVectorData <= selected.vector_data;
      end
    end
  end

  // Scoreboard update: the strobe clears its bit first, a same-cycle reservation then wins.
  always_comb begin
    busy_scalar_next = busy_scalar_reg;
    busy_vector_next = busy_vector_reg;
    if (bus.writeEnableScalar) begin
      busy_scalar_next[bus.writeAddress] = 1'b0;
    end
    if (bus.writeEnableVector) begin
      busy_vector_next[bus.writeAddress] = 1'b0;
    end
    if (reserveValid) begin
      if (reserveIsVector) begin
        busy_vector_next[reserveAddress] = 1'b1;
      end else begin
        busy_scalar_next[reserveAddress] = 1'b1;
      end
    end
  end

  // Busy-bit state; a reset drops every outstanding reservation.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_scalar_reg <= '0;
      busy_vector_reg <= '0;
    end else begin
      busy_scalar_reg <= busy_scalar_next;
      busy_vector_reg <= busy_vector_next;
    end
  end

  // Stall Decode when any operand or the destination is still pending in the queried file.
  assign query_busy = queryIsVector ? busy_vector_reg : busy_scalar_reg;
  assign hazard     = query_busy[reg1Address] | query_busy[reg2Address]
                    | query_busy[regDestinationAddress];

endmodule
